// File: rtl/svd_pkg.sv
// rtl/svd_pkg.sv - shared state encoding and timing constants for the SVD controller
package svd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_ROT_L = 3'd2;
  localparam state_t S_ROT_R = 3'd3;
  localparam state_t S_DUMP  = 3'd4;
  localparam state_t S_DRAIN = 3'd5;
  localparam state_t S_DONE  = 3'd6;

  localparam int CNT_LAST = 17;
  localparam int RD_LAT   = 1;

  function automatic logic is_rot(input state_t s);
    return (s == S_ROT_L) || (s == S_ROT_R);
  endfunction

endpackage

// File: rtl/svd_step_cnt.sv
// rtl/svd_step_cnt.sv - rotation step / sweep counter pair with final-step flag
module svd_step_cnt #(
  parameter int N          = 8,
  parameter int NUM_SWEEPS = 6,
  parameter int STEP_W     = 3,
  parameter int SWEEP_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               adv,
  output logic [STEP_W-1:0]  step,
  output logic [SWEEP_W-1:0] sweep,
  output logic               last
);
  import svd_pkg::*;

  logic step_last;

  assign step_last = (step == STEP_W'(N - 1));
  assign last      = step_last && (sweep == SWEEP_W'(NUM_SWEEPS - 1));

  // sweep saturates on the final step so the finished sweep stays visible until the next job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step  <= '0;
      sweep <= '0;
    end else if (clr) begin
      step  <= '0;
      sweep <= '0;
    end else if (adv) begin
      if (step_last) begin
        step <= '0;
        if (!last) sweep <= sweep + SWEEP_W'(1);
      end else begin
        step <= step + STEP_W'(1);
      end
    end
  end

endmodule

// File: rtl/svd_ctrl.sv
// rtl/svd_ctrl.sv - SVD job sequencer: load, Jacobi rotation sweeps, result dump
module svd_ctrl #(
  parameter int N          = 8,
  parameter int ADDR_W     = 3,
  parameter int NUM_SWEEPS = 6,
  parameter int CNT_LAST   = svd_pkg::CNT_LAST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic              ce_svd,
  input  logic [4:0]        cnt_svd,
  output logic              ce_cnt,
  output logic              ce_cordic_slot0_A,
  output logic              ce_cordic_slot1_A,
  output logic              ce_cordic_slot0_UV,
  output logic              ce_cordic_slot1_UV,
  output logic              mux_ctrl_0,
  output logic              demux_ctrl_0,
  output logic              mux_ctrl_1,
  output logic              demux_ctrl_1,
  output logic [ADDR_W-1:0] sel_cordic_rot,
  output logic [ADDR_W-1:0] addr_A,
  output logic [ADDR_W-1:0] addr_U,
  output logic [ADDR_W-1:0] addr_V,
  output logic              we_A,
  output logic              we_U,
  output logic              we_V,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [2:0]        sweep_idx
);
  import svd_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] word, word_nxt;
  logic [ADDR_W-1:0] step;
  logic              last_step;
  logic              cnt_clr, cnt_adv;
  logic              phase_end;
  logic              word_last;
  logic              rd_q;

  assign phase_end = ce_svd && (cnt_svd == 5'(CNT_LAST));
  assign word_last = (word == ADDR_W'(N - 1));

  svd_step_cnt #(
    .N          (N),
    .NUM_SWEEPS (NUM_SWEEPS),
    .STEP_W     (ADDR_W),
    .SWEEP_W    (3)
  ) u_step_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .adv   (cnt_adv),
    .step  (step),
    .sweep (sweep_idx),
    .last  (last_step)
  );

  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    cnt_clr   = 1'b0;
    cnt_adv   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ce_svd && start) begin
          state_nxt = S_LOAD;
          word_nxt  = '0;
          cnt_clr   = 1'b1;
        end
      end
      S_LOAD: begin
        if (ce_svd && in_valid) begin
          word_nxt = word + ADDR_W'(1);
          if (word_last) begin
            state_nxt = S_ROT_L;
            word_nxt  = '0;
          end
        end
      end
      S_ROT_L: begin
        if (phase_end) state_nxt = S_ROT_R;
      end
      S_ROT_R: begin
        if (phase_end) begin
          cnt_adv   = 1'b1;
          word_nxt  = '0;
          state_nxt = last_step ? S_DUMP : S_ROT_L;
        end
      end
      S_DUMP: begin
        if (ce_svd) begin
          word_nxt = word + ADDR_W'(1);
          if (word_last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ce_svd) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (ce_svd) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      word  <= '0;
      rd_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      word  <= word_nxt;
      // one-cycle DRAM read latency: valid follows the read address
      if (ce_svd) rd_q <= (state == S_DUMP);
    end
  end

  always_comb begin
    ce_cordic_slot0_A  = 1'b0;
    ce_cordic_slot1_A  = 1'b0;
    ce_cordic_slot0_UV = 1'b0;
    ce_cordic_slot1_UV = 1'b0;
    mux_ctrl_0         = 1'b0;
    demux_ctrl_0       = 1'b0;
    mux_ctrl_1         = 1'b0;
    demux_ctrl_1       = 1'b0;
    sel_cordic_rot     = '0;
    addr_A             = '0;
    addr_U             = '0;
    addr_V             = '0;
    we_A               = 1'b0;
    we_U               = 1'b0;
    we_V               = 1'b0;
    done               = 1'b0;
    case (state)
      S_LOAD: begin
        addr_A = word;
        we_A   = in_valid & ce_svd;
      end
      S_ROT_L: begin
        demux_ctrl_0       = 1'b1;
        ce_cordic_slot0_A  = 1'b1;
        ce_cordic_slot0_UV = 1'b1;
        sel_cordic_rot     = step;
        addr_A             = step;
        addr_U             = step;
        mux_ctrl_0         = phase_end;
        we_A               = phase_end;
        we_U               = phase_end;
      end
      S_ROT_R: begin
        demux_ctrl_0       = 1'b1;
        mux_ctrl_1         = 1'b1;
        demux_ctrl_1       = 1'b1;
        ce_cordic_slot1_A  = 1'b1;
        ce_cordic_slot1_UV = 1'b1;
        sel_cordic_rot     = step;
        addr_A             = step;
        addr_V             = step;
        mux_ctrl_0         = phase_end;
        we_A               = phase_end;
        we_V               = phase_end;
      end
      S_DUMP: begin
        addr_A = word;
        addr_U = word;
        addr_V = word;
      end
      S_DONE: done = ce_svd;
      default: ;
    endcase
  end

  assign ce_cnt    = is_rot(state);
  assign busy      = (state != S_IDLE);
  assign out_valid = rd_q & ce_svd;

endmodule

// File: tb/tb_svd_ctrl.sv
// tb/tb_svd_ctrl.sv - self-checking bench for svd_ctrl against a job-level reference model
module tb_svd_ctrl;

  localparam int M_IDLE = 0, M_LOAD = 1, M_ROT = 2, M_DUMP = 3, M_DRAIN = 4, M_DONE = 5;
  localparam int PHASE   = 18;
  localparam int ROT_CYC = 6 * 8 * 2 * PHASE;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, ce_svd = 1'b1;
  logic [4:0] cnt = 5'd0;
  logic [4:0] cnt_svd;
  logic ce_cnt, ce_cordic_slot0_A, ce_cordic_slot1_A, ce_cordic_slot0_UV, ce_cordic_slot1_UV;
  logic mux_ctrl_0, demux_ctrl_0, mux_ctrl_1, demux_ctrl_1;
  logic [2:0] sel_cordic_rot, addr_A, addr_U, addr_V, sweep_idx;
  logic we_A, we_U, we_V, out_valid, busy, done;

  always #5 clk = ~clk;
  assign cnt_svd = cnt;

  svd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .ce_svd(ce_svd),
    .cnt_svd(cnt_svd), .ce_cnt(ce_cnt),
    .ce_cordic_slot0_A(ce_cordic_slot0_A), .ce_cordic_slot1_A(ce_cordic_slot1_A),
    .ce_cordic_slot0_UV(ce_cordic_slot0_UV), .ce_cordic_slot1_UV(ce_cordic_slot1_UV),
    .mux_ctrl_0(mux_ctrl_0), .demux_ctrl_0(demux_ctrl_0), .mux_ctrl_1(mux_ctrl_1),
    .demux_ctrl_1(demux_ctrl_1), .sel_cordic_rot(sel_cordic_rot),
    .addr_A(addr_A), .addr_U(addr_U), .addr_V(addr_V),
    .we_A(we_A), .we_U(we_U), .we_V(we_V), .out_valid(out_valid),
    .busy(busy), .done(done), .sweep_idx(sweep_idx)
  );

  int n_pass = 0, n_total = 0;
  int cyc = 0, t0 = 0;
  int m_stage = M_IDLE, m_words = 0, m_rot = 0, m_sweep = 0;
  logic m_pend = 1'b0;
  logic ce_cnt_s = 1'b0;

  int first_we_a = -1, last_load_we = -1, first_we_u = -1, first_we_v = -1;
  int first_ov = -1, last_ov = -1, ov_cnt = 0, ev_done = -1, max_sw = 0;
  int m_first_we_u = -1, m_done = -1;
  int load_hits [8];

  always @(posedge clk) cyc <= cyc + 1;

  // Job-level model: progress is tracked as words moved and enabled rotation cycles elapsed;
  // the datapath phase counter is modelled here too since it feeds cnt_svd.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage <= M_IDLE; m_words <= 0; m_rot <= 0; m_sweep <= 0; m_pend <= 1'b0; cnt <= 5'd0;
    end else begin
      if (!ce_cnt_s) cnt <= 5'd0;
      else if (ce_svd) cnt <= (cnt == 5'd17) ? 5'd0 : cnt + 5'd1;
      if (ce_svd) begin
        m_pend <= (m_stage == M_DUMP);
        case (m_stage)
          M_IDLE: if (start) begin m_stage <= M_LOAD; m_words <= 0; m_sweep <= 0; end
          M_LOAD: if (in_valid) begin
            if (m_words == 7) begin m_stage <= M_ROT; m_rot <= 0; m_words <= 0; end
            else m_words <= m_words + 1;
          end
          M_ROT: if (m_rot == ROT_CYC - 1) begin
            m_stage <= M_DUMP; m_words <= 0; m_sweep <= 5;
          end else m_rot <= m_rot + 1;
          M_DUMP: if (m_words == 7) m_stage <= M_DRAIN; else m_words <= m_words + 1;
          M_DRAIN: m_stage <= M_DONE;
          default: m_stage <= M_IDLE;
        endcase
      end
    end
  end

  function automatic logic [29:0] dut_vec();
    return {ce_cnt, ce_cordic_slot0_A, ce_cordic_slot1_A, ce_cordic_slot0_UV, ce_cordic_slot1_UV,
            mux_ctrl_0, demux_ctrl_0, mux_ctrl_1, demux_ctrl_1, sel_cordic_rot,
            addr_A, addr_U, addr_V, we_A, we_U, we_V, out_valid, busy, done, sweep_idx};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic compare_loop();
    int c, ph, pos, stp;
    logic left, wr;
    logic e_cnt, e_s0a, e_s1a, e_s0uv, e_s1uv, e_m0, e_d0, e_m1, e_d1;
    logic e_wa, e_wu, e_wv, e_ov, e_busy, e_done;
    logic [2:0] e_sel, e_aa, e_au, e_av, e_sw;
    forever begin
      @(negedge clk);
      ce_cnt_s = ce_cnt;
      if (rst_n) begin
        c = cyc - t0;
        if (c == 0) begin
          first_we_a = -1; last_load_we = -1; first_we_u = -1; first_we_v = -1;
          first_ov = -1; last_ov = -1; ov_cnt = 0; ev_done = -1; max_sw = 0;
          m_first_we_u = -1; m_done = -1;
          for (int i = 0; i < 8; i++) load_hits[i] = 0;
        end
        {e_cnt, e_s0a, e_s1a, e_s0uv, e_s1uv, e_m0, e_d0, e_m1, e_d1} = '0;
        {e_wa, e_wu, e_wv, e_done} = '0;
        {e_sel, e_aa, e_au, e_av} = '0;
        e_sw   = 3'(m_sweep);
        e_busy = (m_stage != M_IDLE);
        e_ov   = m_pend & ce_svd;
        case (m_stage)
          M_LOAD: begin e_aa = 3'(m_words); e_wa = in_valid & ce_svd; end
          M_ROT: begin
            ph = m_rot / PHASE; pos = m_rot % PHASE; stp = (ph / 2) % 8;
            left = (ph % 2) == 0; wr = (pos == PHASE - 1) && ce_svd;
            e_cnt = 1'b1; e_d0 = 1'b1; e_m1 = !left; e_d1 = !left;
            e_s0a = left; e_s0uv = left; e_s1a = !left; e_s1uv = !left;
            e_sel = 3'(stp); e_aa = 3'(stp);
            e_au = left ? 3'(stp) : 3'd0; e_av = left ? 3'd0 : 3'(stp);
            e_m0 = wr; e_wa = wr; e_wu = wr & left; e_wv = wr & !left;
            e_sw = 3'(ph / 16);
          end
          M_DUMP: begin e_aa = 3'(m_words); e_au = 3'(m_words); e_av = 3'(m_words); end
          M_DONE: e_done = ce_svd;
          default: ;
        endcase
        chk($sformatf("outputs@cycle%0d", c), dut_vec(),
            {e_cnt, e_s0a, e_s1a, e_s0uv, e_s1uv, e_m0, e_d0, e_m1, e_d1, e_sel,
             e_aa, e_au, e_av, e_wa, e_wu, e_wv, e_ov, e_busy, e_done, e_sw});
        if (we_A && busy && !mux_ctrl_0) begin
          if (first_we_a < 0) first_we_a = c;
          last_load_we = c;
          load_hits[addr_A] = load_hits[addr_A] + 1;
        end
        if (we_U && first_we_u < 0) first_we_u = c;
        if (we_V && first_we_v < 0) first_we_v = c;
        if (out_valid) begin
          if (first_ov < 0) first_ov = c;
          last_ov = c;
          ov_cnt++;
        end
        if (done) ev_done = c;
        if (int'(sweep_idx) > max_sw) max_sw = int'(sweep_idx);
        if (e_wu && m_first_we_u < 0) m_first_we_u = c;
        if (e_done) m_done = c;
      end
    end
  endtask

  // mode: 0 nominal, 1 in_valid toggling, 2 stall in ROT_L, 3 start noise, 4 reset abort
  task automatic run_job(input int mode);
    int k;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; ce_svd = 1'b1; t0 = cyc;
    k = 0;
    while (k < 2500) begin
      @(posedge clk); #1;
      k++;
      start    = (mode == 3) && (k == 5 || k == 300 || k == 900 || k == 1740);
      in_valid = (mode == 1) ? (k % 2 == 0) : 1'b1;
      ce_svd   = !(mode == 2 && k >= 19 && k <= 23);
      if (mode == 4 && k == 44) begin
        #2;
        chk("we_v_pending_before_reset", we_V, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", dut_vec(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        break;
      end
      if (ev_done >= 0) break;
    end
    start = 1'b0;
    if (mode != 4) chk("job_completes_in_budget", ev_done >= 0, 1);
  endtask

  task automatic check_loads(input int last_we);
    int ok;
    ok = 1;
    for (int i = 0; i < 8; i++) if (load_hits[i] != 1) ok = 0;
    chk("load_each_addr_once", ok, 1);
    chk("last_load_write_cycle", last_load_we, last_we);
  endtask

  task automatic check_nominal();
    chk("first_we_a_cycle", first_we_a, 1);
    check_loads(8);
    chk("first_we_u_cycle", first_we_u, 26);
    chk("first_we_v_cycle", first_we_v, 44);
    chk("model_first_we_u", m_first_we_u, 26);
    chk("first_out_valid", first_ov, 1738);
    chk("last_out_valid", last_ov, 1745);
    chk("out_valid_count", ov_cnt, 8);
    chk("done_cycle", ev_done, 1746);
    chk("model_done_cycle", m_done, 1746);
    chk("max_sweep_idx", max_sw, 5);
  endtask

  initial begin
    fork
      compare_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", dut_vec(), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_job(0);
    check_nominal();

    run_job(3);
    check_nominal();
    chk("sweep_held_in_idle", sweep_idx, 5);
    chk("idle_after_done", busy, 0);

    run_job(1);
    chk("toggle_first_we_a", first_we_a, 2);
    check_loads(16);
    chk("toggle_first_we_u", first_we_u, 34);
    chk("toggle_first_we_v", first_we_v, 52);
    chk("toggle_done_cycle", ev_done, 1754);
    chk("toggle_model_done", m_done, 1754);

    run_job(2);
    chk("stall_first_we_u", first_we_u, 31);
    chk("stall_model_we_u", m_first_we_u, 31);
    chk("stall_first_we_v", first_we_v, 49);
    chk("stall_done_cycle", ev_done, 1751);

    run_job(4);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_abort", busy, 0);

    run_job(0);
    check_nominal();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
